// File: rtl/char_buf_arb_pkg.sv
// ---------------------------------------------------------------------------
// CharBufArbPkg
// Shared types and constants for the character-buffer write-port arbiter.
//   state_t   : arbiter FSM states (INSERT used only when CHAR_BUF_ARB_SEP_EN
//               is defined)
//   dbg_t     : debug view of the FSM state and the column-0 flag
//   ASCII_*   : control characters the arbiter reacts to
//   is_eol()  : true for characters that end a producer's line
// ---------------------------------------------------------------------------
package CharBufArbPkg;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      GRANT  = 2'd1,
      INSERT = 2'd2
   } state_t;

   typedef struct packed {
      state_t state;
      logic   col0;
   } dbg_t;

   localparam logic [7:0] ASCII_LF  = 8'h0A;
   localparam logic [7:0] ASCII_ESC = 8'h1B;
   localparam logic [7:0] ASCII_DEL = 8'h7F;

   function automatic logic is_eol(input logic [7:0] c);
      return (c == ASCII_LF) || (c == ASCII_ESC);
   endfunction

endpackage

// File: rtl/char_buf_arb_rr_pick.sv
// ---------------------------------------------------------------------------
// RRPick
// Combinational round-robin picker. Returns the first index with val set,
// searching from last+1 and wrapping modulo p_num_reqs. The previous winner
// is checked last, so it only wins again when nobody else is asking.
//   val  in  p_num_reqs       : request vector
//   last in  clog2(p_num_reqs): previous winner
//   idx  out clog2(p_num_reqs): selected index (0 when any==0)
//   any  out 1                : at least one request is set
// ---------------------------------------------------------------------------
module RRPick #(
   parameter int p_num_reqs = 2
) (
   input  logic [p_num_reqs-1:0]         val,
   input  logic [$clog2(p_num_reqs)-1:0] last,
   output logic [$clog2(p_num_reqs)-1:0] idx,
   output logic                          any
);

   localparam int W = $clog2(p_num_reqs);

   logic [W-1:0] cand;

   always_comb begin
      idx  = '0;
      any  = 1'b0;
      cand = '0;
      for (int i = 1; i <= p_num_reqs; i++) begin
         cand = W'((int'(last) + i) % p_num_reqs);
         if (!any && val[cand]) begin
            any = 1'b1;
            idx = cand;
         end
      end
   end

endmodule

// File: rtl/char_buf_arb.sv
// ---------------------------------------------------------------------------
// char_buf_arb
// Round-robin arbiter sharing the character buffer's single write port among
// several ASCII producers. A grant is held until the owner sends LF/ESC,
// reaches p_max_burst characters, or stays idle for p_idle_cycles cycles.
//
// Handshake: a character moves from requester i when req_val[i] & req_rdy[i]
// in the same cycle. req_rdy is decoded from registers only and never looks
// at req_val; a producer may drop req_val at any time. The output side has no
// backpressure: ascii_val pulses for one cycle per character, one cycle after
// its transfer, and ascii holds its last value otherwise.
//
// Optional feature: CHAR_BUF_ARB_SEP_EN. When defined, a grant moving to a
// different producer while the buffer is mid-line first emits a separator LF
// (INSERT state) so two producers' text never shares a line.
//
// Ports:
//   clk        in  1                  clock
//   rst        in  1                  synchronous active-high reset
//   req_ascii  in  8*p_num_reqs       character of requester i at [8i+7:8i]
//   req_val    in  p_num_reqs         requester i offers a character
//   req_rdy    out p_num_reqs         requester i's character is taken
//   ascii      out 8                  character to the buffer
//   ascii_val  out 1                  ascii valid this cycle
//   owner      out clog2(p_num_reqs)  current or most recent grant holder
//   dbg        out dbg_t              FSM state and column-0 flag
// ---------------------------------------------------------------------------
module char_buf_arb
   import CharBufArbPkg::*;
#(
   parameter int p_num_reqs    = 2,
   parameter int p_max_burst   = 32,
   parameter int p_idle_cycles = 4
) (
   input  logic                          clk,
   input  logic                          rst,
   input  logic [8*p_num_reqs-1:0]       req_ascii,
   input  logic [p_num_reqs-1:0]         req_val,
   output logic [p_num_reqs-1:0]         req_rdy,
   output logic [7:0]                    ascii,
   output logic                          ascii_val,
   output logic [$clog2(p_num_reqs)-1:0] owner,
   output dbg_t                          dbg
);

   localparam int         OW        = $clog2(p_num_reqs);
   localparam logic [7:0] MAX_BURST = 8'(p_max_burst);
   localparam logic [7:0] IDLE_LIM  = 8'(p_idle_cycles);

   state_t        state;
   logic [7:0]    burst_cnt;
   logic [7:0]    idle_cnt;
   logic          col0;

   logic [OW-1:0] pick;
   logic          pick_any;
   logic          own_val;
   logic [7:0]    own_char;
   logic          xfer;
   logic [7:0]    burst_next;
   logic [7:0]    idle_next;

   RRPick #(.p_num_reqs(p_num_reqs)) u_pick (
      .val  (req_val),
      .last (owner),
      .idx  (pick),
      .any  (pick_any)
   );

   assign own_val    = req_val[owner];
   assign own_char   = req_ascii[{owner, 3'b000} +: 8];
   assign xfer       = (state == GRANT) && own_val;
   assign burst_next = burst_cnt + 8'd1;
   assign idle_next  = idle_cnt + 8'd1;

   always_comb begin
      req_rdy = '0;
      if (state == GRANT) req_rdy[owner] = 1'b1;
   end

   assign dbg.state = state;
   assign dbg.col0  = col0;

   always_ff @(posedge clk) begin
      if (rst) begin
         state     <= IDLE;
         owner     <= OW'(p_num_reqs - 1);  // requester 0 wins first
         burst_cnt <= '0;
         idle_cnt  <= '0;
         col0      <= 1'b1;
         ascii     <= '0;
         ascii_val <= 1'b0;
      end else begin
         ascii_val <= 1'b0;
         case (state)
            IDLE: begin
               if (pick_any) begin
                  owner     <= pick;
                  burst_cnt <= '0;
                  idle_cnt  <= '0;
`ifdef CHAR_BUF_ARB_SEP_EN
                  // New producer while the buffer is mid-line: break the line.
                  if ((pick != owner) && !col0) state <= INSERT;
                  else                          state <= GRANT;
`else
                  state <= GRANT;
`endif
               end
            end

            GRANT: begin
               if (xfer) begin
                  ascii     <= own_char;
                  ascii_val <= 1'b1;
                  burst_cnt <= burst_next;
                  idle_cnt  <= '0;
                  // DEL erases in place, so it leaves the column flag alone.
                  if (is_eol(own_char))            col0 <= 1'b1;
                  else if (own_char != ASCII_DEL)  col0 <= 1'b0;
                  if (is_eol(own_char) || (burst_next == MAX_BURST))
                     state <= IDLE;
               end else begin
                  idle_cnt <= idle_next;
                  if (idle_next == IDLE_LIM) state <= IDLE;
               end
            end

`ifdef CHAR_BUF_ARB_SEP_EN
            INSERT: begin
               // Separator LF is not a producer character: burst untouched.
               ascii     <= ASCII_LF;
               ascii_val <= 1'b1;
               col0      <= 1'b1;
               state     <= GRANT;
            end
`endif

            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_char_buf_arb.sv
// ---------------------------------------------------------------------------
// tb_char_buf_arb
// Bench for char_buf_arb with p_num_reqs=2, p_max_burst=4, p_idle_cycles=3.
// Producers are per-requester character queues. A cycle-level reference of
// the arbitration rules predicts req_rdy/owner and pushes each accepted
// character (and separator LF when CHAR_BUF_ARB_SEP_EN is defined) into
// exp_q; an independent monitor pops exp_q whenever ascii_val is high.
// ---------------------------------------------------------------------------
module tb_char_buf_arb;
   import CharBufArbPkg::*;

   localparam int N     = 2;
   localparam int MAXB  = 4;
   localparam int IDLEC = 3;
`ifdef CHAR_BUF_ARB_SEP_EN
   localparam bit SEP = 1'b1;
`else
   localparam bit SEP = 1'b0;
`endif

   // ---------------- clock / reset ----------------
   logic           clk = 1'b0;
   logic           rst;
   logic [8*N-1:0] req_ascii;
   logic [N-1:0]   req_val;
   logic [N-1:0]   req_rdy;
   logic [7:0]     ascii;
   logic           ascii_val;
   logic [0:0]     owner;
   dbg_t           dbg;

   always #5 clk = ~clk;

   char_buf_arb #(
      .p_num_reqs    (N),
      .p_max_burst   (MAXB),
      .p_idle_cycles (IDLEC)
   ) dut (
      .clk       (clk),
      .rst       (rst),
      .req_ascii (req_ascii),
      .req_val   (req_val),
      .req_rdy   (req_rdy),
      .ascii     (ascii),
      .ascii_val (ascii_val),
      .owner     (owner),
      .dbg       (dbg)
   );

   // ---------------- scoreboard state ----------------
   int         n_cmp = 0;
   int         n_bad = 0;
   logic [7:0] exp_q[$];
   logic [7:0] src_q[N][$];
   logic [N-1:0] took;
   bit         rand_val = 1'b0;
   bit         mon_en   = 1'b0;
   logic [7:0] last_out = 8'h00;

   // reference: 0 idle, 1 granted, 2 separator pending
   int         m_st, m_own, m_burst, m_idle;
   bit         m_col0;

   task automatic check(input string name, input logic [31:0] act,
                        input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic model_reset();
      m_st = 0; m_own = N - 1; m_burst = 0; m_idle = 0; m_col0 = 1'b1;
      took = '0;
   endtask

   // One cycle of the arbitration rules, using this cycle's inputs.
   task automatic model_step();
      logic [N-1:0] erdy;
      logic [7:0]   c;
      int           k, cand;
      bit           found;
      erdy = '0;
      if (m_st == 1) erdy[m_own] = 1'b1;
      check("req_rdy", req_rdy, erdy);
      check("owner", owner, m_own);
      took = '0;
      case (m_st)
         0: begin
            found = 1'b0; k = 0;
            for (int i = 1; i <= N; i++) begin
               cand = (m_own + i) % N;
               if (!found && req_val[cand]) begin found = 1'b1; k = cand; end
            end
            if (found) begin
               m_st = (SEP && (k != m_own) && !m_col0) ? 2 : 1;
               m_own = k; m_burst = 0; m_idle = 0;
            end
         end
         1: begin
            if (req_val[m_own]) begin
               c = req_ascii[m_own*8 +: 8];
               exp_q.push_back(c);
               took[m_own] = 1'b1;
               m_burst++;
               m_idle = 0;
               if (c == 8'h0A || c == 8'h1B) m_col0 = 1'b1;
               else if (c != 8'h7F)          m_col0 = 1'b0;
               if (c == 8'h0A || c == 8'h1B || m_burst == MAXB) m_st = 0;
            end else begin
               m_idle++;
               if (m_idle == IDLEC) m_st = 0;
            end
         end
         default: begin
            exp_q.push_back(8'h0A);
            m_col0 = 1'b1;
            m_st = 1;
         end
      endcase
   endtask

   // ---------------- driver ----------------
   task automatic drive_next();
      for (int r = 0; r < N; r++) begin
         if (took[r]) void'(src_q[r].pop_front());
         if (src_q[r].size() > 0) begin
            req_ascii[r*8 +: 8] = src_q[r][0];
            req_val[r] = rand_val ? ($urandom_range(0, 3) != 0) : 1'b1;
         end else begin
            req_ascii[r*8 +: 8] = 8'h00;
            req_val[r] = 1'b0;
         end
      end
      took = '0;
   endtask

   task automatic cycle();
      @(negedge clk);
      drive_next();
      model_step();
   endtask

   task automatic load(input int r, input string s);
      for (int i = 0; i < s.len(); i++) src_q[r].push_back(s[i]);
   endtask

   function automatic bit all_done();
      bit d;
      d = (m_st == 0) && (req_val == '0);
      for (int r = 0; r < N; r++) if (src_q[r].size() != 0) d = 1'b0;
      return d;
   endfunction

   task automatic run(input string name, input int budget);
      int b;
      b = budget;
      while (!all_done()) begin
         cycle();
         b--;
         if (b == 0) begin
            n_cmp++; n_bad++;
            $display("FAIL %s: drain timeout after %0d cycles", name, budget);
            break;
         end
      end
      repeat (2) cycle();
      check({name, "_drained"}, exp_q.size(), 0);
   endtask

   function automatic logic [7:0] rand_char();
      int s;
      s = $urandom_range(0, 9);
      if (s == 0) return 8'h0A;
      if (s == 1) return 8'h1B;
      if (s == 2) return 8'h7F;
      return 8'(8'h41 + $urandom_range(0, 25));
   endfunction

   // ---------------- monitor ----------------
   always @(negedge clk) begin
      if (mon_en) begin
         if (ascii_val) begin
            if (exp_q.size() == 0) begin
               n_cmp++; n_bad++;
               $display("FAIL ascii_unexpected: got 0x%0h expected no output at %0t",
                        ascii, $time);
            end else begin
               check("ascii", ascii, exp_q.pop_front());
            end
            last_out = ascii;
         end else begin
            check("ascii_hold", ascii, last_out);
         end
      end
   end

   // ---------------- watchdog ----------------
   initial begin
      #2000000;
      $display("FAIL watchdog: simulation time limit reached");
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad + 1);
      $fatal(1, "time limit");
   end

   // ---------------- stimulus ----------------
   initial begin
      int ok;
      rst = 1'b1;
      req_val = '0;
      req_ascii = '0;
      model_reset();
      repeat (2) @(negedge clk);
      check("rst_req_rdy", req_rdy, 0);
      check("rst_ascii_val", ascii_val, 0);
      check("rst_ascii", ascii, 8'h00);
      check("rst_owner", owner, N - 1);
      check("rst_col0", dbg.col0, 1);
      check("rst_state", dbg.state, IDLE);
      rst = 1'b0;
      mon_en = 1'b1;

      // single requester
      load(0, "AB");
      run("single", 40);

      // line hold: req1 waits for req0's LF
      load(0, "X\n");
      load(1, "yz");
      run("line_hold", 60);

      // burst limit
      load(0, "AAAAAA");
      load(1, "bb");
      run("burst", 80);

      // idle release
      load(0, "Q");
      load(1, "r");
      run("idle_rel", 60);

      // DEL passthrough, grant held
      load(0, {"A", 8'h7F});
      run("del", 40);

      // reset mid-grant while req1 streams
      load(1, "mnopqrs");
      ok = 0;
      for (int i = 0; i < 30; i++) begin
         cycle();
         if (m_st == 1 && m_own == 1 && m_burst >= 1) begin ok = 1; break; end
      end
      check("midgrant_reached", ok, 1);
      load(0, "k");
      @(negedge clk);
      drive_next();
      rst = 1'b1;
      @(negedge clk);
      check("midrst_req_rdy", req_rdy, 0);
      check("midrst_ascii_val", ascii_val, 0);
      check("midrst_owner", owner, N - 1);
      rst = 1'b0;
      model_reset();
      exp_q.delete();
      last_out = 8'h00;
      drive_next();
      model_step();
      run("after_rst", 100);

      // randomized traffic
      rand_val = 1'b1;
      for (int it = 0; it < 40; it++) begin
         for (int r = 0; r < N; r++) begin
            int len;
            len = $urandom_range(0, 7);
            for (int j = 0; j < len; j++) src_q[r].push_back(rand_char());
         end
         run("random", 400);
      end

      check("final_exp_q_empty", exp_q.size(), 0);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule

// File: doc/char_buf_arb.md
# char_buf_arb

Round-robin arbiter that shares the single write port of the character buffer between several ASCII producers, such as a UART receiver, a keyboard decoder and a status-message ROM. Each producer sees a valid/ready interface. The arbiter keeps one producer's text contiguous by holding a grant until that producer ends a line, hits a burst limit or goes idle. Its output drives the character buffer's `ascii`/`ascii_val` directly, one character per cycle with no backpressure.

## Interface
- `p_num_reqs`, default 2 — number of requesters, 2..8.
- `p_max_burst`, default 32 — maximum characters accepted per grant before forced rotation, 1..255.
- `p_idle_cycles`, default 4 — consecutive owner-idle cycles that release a grant, 1..255.

Ports:
- `clk`  in  1 — the single clock.
- `rst`  in  1 — reset, synchronous and active-high.
- `req_ascii`  in  `8*p_num_reqs` — character from requester i, in bits `[8i+7:8i]`.
- `req_val`  in  `p_num_reqs` — requester i has a character.
- `req_rdy`  out  `p_num_reqs` — requester i's character is accepted this cycle.
- `ascii`  out  8 — character to the buffer.
- `ascii_val`  out  1 — `ascii` is valid this cycle.
- `owner`  out  `$clog2(p_num_reqs)` — current or most recent grant holder, for debug.

## Operation
- States: IDLE, GRANT, plus INSERT when the configuration macro is enabled.
- Transfer: occurs when `req_val[i] & req_rdy[i]`.
- `req_rdy`: `req_rdy[i] = (state==GRANT) & (owner==i)`. It is decoded from registers only and never depends on `req_val`.
- IDLE:
  - If any `req_val` is high, pick the first requester with `req_val` high, searching from `owner+1` and wrapping modulo `p_num_reqs`.
  - Register the pick into `owner`, clear the burst and idle counters, and go to GRANT (or INSERT, see Configuration).
  - If no `req_val` is high, stay in IDLE.
- GRANT, leave for IDLE at the end of the cycle in which any of these holds:
  - the transferred character is LF (0x0A) or ESC (0x1B);
  - the burst counter reaches `p_max_burst` on this transfer;
  - the idle counter reaches `p_idle_cycles`.
- Burst counter: increments on each transfer.
- Idle counter: increments on each GRANT cycle where the owner's `req_val` is low, and resets to 0 on each transfer.
- Characters pass through unmodified, including DEL (0x7F), LF and ESC. Arbitration never filters or reorders a requester's stream.
- `col0` flag:
  - set on reset and on emitting LF or ESC;
  - cleared on emitting any other character except DEL;
  - unchanged by DEL.

## Timing
- Reset values:
  - state IDLE;
  - `owner = p_num_reqs-1`, so requester 0 wins the first arbitration;
  - `req_rdy` all 0, `ascii` 0x00, `ascii_val` 0;
  - counters 0, `col0` 1.
- Grant latency: `req_val` rising in IDLE produces `req_rdy` high on the following cycle (1 cycle).
- Output latency: a transfer in cycle N produces `ascii`/`ascii_val` in cycle N+1. `ascii` holds its last value while `ascii_val` is 0.
- Throughput: one character per cycle while granted. A release costs at least one IDLE cycle (no transfers) before the next grant.
- Release: `req_rdy` drops in the cycle after the terminating transfer or timeout.
- If the owner's `req_val` falls and rises again before the idle counter expires, the owner keeps the grant.
- Reset asserted mid-grant or mid-INSERT: all state returns to reset values on the next edge. No partial character is emitted.

## Configuration
- `CHAR_BUF_ARB_SEP_EN` defined:
  - When IDLE selects an owner different from the previous owner and `col0==0`, enter INSERT for one cycle and then GRANT.
  - During INSERT, `req_rdy` is 0. INSERT registers a separator LF (0x0A), which appears on `ascii`/`ascii_val` the following cycle, and sets `col0`.
  - The inserted LF does not count toward the burst limit.
- Undefined: INSERT does not exist, IDLE always goes directly to GRANT, and output characters are exactly the accepted characters.

## Structure
- Package `CharBufArbPkg` holds:
  - the state enum (IDLE, GRANT, INSERT);
  - constants `ASCII_LF = 8'h0A`, `ASCII_ESC = 8'h1B`, `ASCII_DEL = 8'h7F`.
- Sub-module `RRPick`: combinational round-robin picker (`val` vector plus last index in, index and `any` out), parameterized by `p_num_reqs`.
- The top level holds the FSM, counters, `col0` flag and output registers.

## Test plan
All scenarios use `p_num_reqs=2`, `p_max_burst=4`, `p_idle_cycles=3`.
- Single requester:
  - Stimulus: after reset, req0 streams "AB".
  - Response: `req_rdy[0]` high 1 cycle after `req_val[0]`; `ascii` shows 'A' then 'B' on consecutive cycles, each 1 cycle after its transfer; `owner=0`.
- Line hold:
  - Stimulus: req0 and req1 both valid; req0 sends "X", LF.
  - Response: req1 gets no `req_rdy` until after req0's LF. The output stream is "X", LF, then req1's data, with exactly one IDLE gap.
- Burst limit:
  - Stimulus: both valid; req0 sends "AAAAAA" without LF.
  - Response: 4 'A's, then req1 is granted; req0 resumes after req1 releases.
- Idle release:
  - Stimulus: req0 sends "Q", then drops `req_val` for 3 cycles while req1 is valid.
  - Response: grant moves to req1. With `CHAR_BUF_ARB_SEP_EN` defined, an LF (0x0A) precedes req1's first character; without it, no LF appears.
- Reset mid-grant:
  - Stimulus: assert `rst` while req1 owns the grant mid-stream.
  - Response: next cycle `req_rdy=0`, `ascii_val=0`; after release, req0 wins first.
- DEL passthrough:
  - Stimulus: req0 sends "A", DEL.
  - Response: output is 0x41 then 0x7F, and the grant is held.
